pipe_stage_chain: RTL

- Parametrised pipeline-register chain with per-stage stall, flush and valid tracking. Replaces the fixed, always-enabled IF/ID, ID/EX, EX/MEM and MEM/WB registers of the MIPS pipeline.
- A hazard unit drives its stall and flush vectors. Stalls propagate backward and bubbles are inserted at the stall boundary.
- Saturating stall and bubble counters provide CPI measurement.

---
 rtl/pipe_stage_chain.sv | 107 ++++++++++
 1 files changed

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - pipeline register chain with per-stage stall, flush, bubble insertion and CPI counters
module pipe_stage_chain #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall_vec,
    input  logic [STAGES-1:0]       flush_vec,
    input  logic                    cnt_clr,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        stall_count,
    output logic [CNT_W-1:0]        bubble_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
    logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]              bubble_cnt_q, bubble_cnt_d;

    logic [STAGES-1:0]             hold;
    logic [STAGES-1:0]             hold_prev;
    logic [STAGES-1:0]             prev_valid;
    logic [STAGES-1:0][WIDTH-1:0]  prev_data;
    logic                          bubble_hit;

    // A stall anywhere downstream freezes this stage and everything before it.
    always_comb begin
        hold = '0;
        for (int k = 0; k < STAGES; k++) begin
            hold[k] = |(stall_vec >> k);
        end
    end

    assign hold_prev  = {hold[STAGES-2:0], 1'b0};
    assign prev_valid = {valid_q[STAGES-2:0], in_valid};
    assign prev_data  = {data_q[STAGES-2:0], in_data};

    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        bubble_hit = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (flush_vec[k]) begin
                valid_d[k] = 1'b0;
                data_d[k]  = '0;
            end else if (!hold[k]) begin
                if (hold_prev[k]) begin
                    valid_d[k] = 1'b0;
                    data_d[k]  = '0;
                    bubble_hit = bubble_hit | prev_valid[k];
                end else begin
                    valid_d[k] = prev_valid[k];
                    data_d[k]  = prev_data[k];
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (hold[0] && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (bubble_hit && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            data_q       <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign in_ready     = ~hold[0];
    assign stage_valid  = valid_q;
    assign stage_data   = data_q;
    assign out_valid    = valid_q[STAGES-1];
    assign out_data     = data_q[STAGES-1];
    assign stall_count  = stall_cnt_q;
    assign bubble_count = bubble_cnt_q;

endmodule
